// File: rtl/pipe_stage_reg.sv
// Pipeline register between stages with a valid/ready handshake, an optional
// two-entry skid buffer, bubble-insert flush and a saturating stall counter.
module pipe_stage_reg #(
    parameter int DATA_W = 116,
    parameter int CTRL_W = 7,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic              mValid_q, mValid_d;
    logic [DATA_W-1:0] mData_q, mData_d;
    logic [CTRL_W-1:0] mCtrl_q, mCtrl_d;
    logic              sValid_q, sValid_d;
    logic [DATA_W-1:0] sData_q, sData_d;
    logic [CTRL_W-1:0] sCtrl_q, sCtrl_d;
    logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;

    logic inReady;
    logic inFire;
    logic outFire;
    logic stallEvent;

    // With the skid buffer, ready comes only from registered state so that
    // back-pressure never forms a combinational path from out_ready.
    always_comb begin
        if (SKID != 0) begin
            inReady = ~sValid_q & ~flush_i;
        end else begin
            inReady = (~mValid_q | out_ready_i) & ~flush_i;
        end
    end

    assign inFire     = in_valid_i & inReady;
    assign outFire    = mValid_q & out_ready_i;
    assign stallEvent = mValid_q & ~out_ready_i;

    // Every path that empties a register also zeroes its control bits, so a
    // bubble can never carry live control downstream.
    always_comb begin
        mValid_d = mValid_q;
        mData_d  = mData_q;
        mCtrl_d  = mCtrl_q;
        sValid_d = sValid_q;
        sData_d  = sData_q;
        sCtrl_d  = sCtrl_q;
        if (flush_i) begin
            mValid_d = 1'b0;
            mCtrl_d  = '0;
            sValid_d = 1'b0;
            sCtrl_d  = '0;
        end else if (SKID != 0) begin
            if (!mValid_q || outFire) begin
                if (sValid_q) begin
                    mValid_d = 1'b1;
                    mData_d  = sData_q;
                    mCtrl_d  = sCtrl_q;
                    if (inFire) begin
                        sData_d = in_data_i;
                        sCtrl_d = in_ctrl_i;
                    end else begin
                        sValid_d = 1'b0;
                        sCtrl_d  = '0;
                    end
                end else if (inFire) begin
                    mValid_d = 1'b1;
                    mData_d  = in_data_i;
                    mCtrl_d  = in_ctrl_i;
                end else begin
                    mValid_d = 1'b0;
                    mCtrl_d  = '0;
                end
            end else if (inFire) begin
                sValid_d = 1'b1;
                sData_d  = in_data_i;
                sCtrl_d  = in_ctrl_i;
            end
        end else begin
            if (inFire) begin
                mValid_d = 1'b1;
                mData_d  = in_data_i;
                mCtrl_d  = in_ctrl_i;
            end else if (outFire) begin
                mValid_d = 1'b0;
                mCtrl_d  = '0;
            end
        end
    end

    always_comb begin
        stallCnt_d = stallCnt_q;
        if (stallEvent && (stallCnt_q != {CNT_W{1'b1}})) begin
            stallCnt_d = stallCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mValid_q   <= 1'b0;
            mData_q    <= '0;
            mCtrl_q    <= '0;
            sValid_q   <= 1'b0;
            sData_q    <= '0;
            sCtrl_q    <= '0;
            stallCnt_q <= '0;
        end else begin
            mValid_q   <= mValid_d;
            mData_q    <= mData_d;
            mCtrl_q    <= mCtrl_d;
            sValid_q   <= sValid_d;
            sData_q    <= sData_d;
            sCtrl_q    <= sCtrl_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    assign in_ready_o  = inReady;
    assign out_valid_o = mValid_q;
    assign out_data_o  = mData_q;
    assign out_ctrl_o  = mCtrl_q;
    assign stall_cnt_o = stallCnt_q;

endmodule
